// File: rtl/mmio_port_responder_pkg.sv
// Shared definitions for the MMIO port responder: register offsets,
// STATUS bit positions and a helper that assembles the STATUS word.
package mmio_port_responder_pkg;

  localparam logic [3:0] OFF_PORT_OUT = 4'h0;
  localparam logic [3:0] OFF_PORT_IN  = 4'h4;
  localparam logic [3:0] OFF_STATUS   = 4'h8;
  localparam logic [3:0] OFF_TXDATA   = 4'hC;

  localparam int unsigned ST_IN_CHANGED = 0;
  localparam int unsigned ST_OVERFLOW   = 1;
  localparam int unsigned ST_EMPTY      = 2;
  localparam int unsigned ST_FULL       = 3;
  localparam int unsigned ST_COUNT_LSB  = 4;

  // Word select within the 16-byte window (Address[3:2]).
  typedef enum logic [1:0] {
    REG_PORT_OUT = OFF_PORT_OUT[3:2],
    REG_PORT_IN  = OFF_PORT_IN[3:2],
    REG_STATUS   = OFF_STATUS[3:2],
    REG_TXDATA   = OFF_TXDATA[3:2]
  } reg_sel_e;

  function automatic logic [31:0] pack_status(input logic       in_changed,
                                               input logic       overflow,
                                               input logic       empty,
                                               input logic       full,
                                               input logic [3:0] count);
    logic [31:0] s;
    s = '0;
    s[ST_IN_CHANGED]                 = in_changed;
    s[ST_OVERFLOW]                   = overflow;
    s[ST_EMPTY]                      = empty;
    s[ST_FULL]                       = full;
    s[ST_COUNT_LSB+3:ST_COUNT_LSB]   = count;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Pointer-based synchronous FIFO. Head is presented from registered state
// only (no path from pop to dout). A push while full is accepted only when
// a pop frees a slot in the same cycle.
module sync_fifo_ptr #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder for a 16-byte window on the data bus: output port register,
// synchronised input port with change detect, STATUS with W1C sticky bits,
// and a TX FIFO drained over a valid/ready handshake.
module mmio_port_responder
  import mmio_port_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IN_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  output logic [31:0]         ReadData,
  output logic                Hit,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic [31:0]         TxData,
  output logic                TxValid,
  input  logic                TxReady
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [IN_WIDTH-1:0] sync1;
  logic [IN_WIDTH-1:0] sync2;
  logic [IN_WIDTH-1:0] prev_in;
  logic                in_changed;
  logic                overflow;
  reg_sel_e            sel;
  logic                wr_hit;
  logic                rd_hit;
  logic                clr_status;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CW-1:0]       count;
  logic [31:0]         status;

  assign Hit        = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
  assign sel        = reg_sel_e'(Address[3:2]);
  assign wr_hit     = Hit & MemWrite;
  assign rd_hit     = Hit & MemRead;
  assign clr_status = wr_hit && (sel == REG_STATUS);
  assign push       = wr_hit && (sel == REG_TXDATA);
  assign TxValid    = ~empty;
  assign pop        = TxValid & TxReady;
  assign status     = pack_status(in_changed, overflow, empty, full, 4'(count));

  sync_fifo_ptr #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (WriteData),
    .dout  (TxData),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Load data mux; reflects pre-edge state and is zero unless a hit load.
  always_comb begin
    ReadData = '0;
    if (rd_hit) begin
      unique case (sel)
        REG_PORT_OUT: ReadData = PortOut;
        REG_PORT_IN:  ReadData = 32'(sync2);
        REG_STATUS:   ReadData = status;
        REG_TXDATA:   ReadData = '0;
      endcase
    end
  end

  // Port register, input synchroniser and sticky status (set beats W1C).
  always_ff @(posedge clk) begin
    if (reset) begin
      PortOut    <= '0;
      sync1      <= '0;
      sync2      <= '0;
      prev_in    <= '0;
      in_changed <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      sync1   <= PortIn;
      sync2   <= sync1;
      prev_in <= sync2;
      if (wr_hit && (sel == REG_PORT_OUT)) PortOut <= WriteData;
      in_changed <= (sync2 != prev_in)
                  | (in_changed & ~(clr_status & WriteData[ST_IN_CHANGED]));
      overflow   <= (push & full & ~pop)
                  | (overflow & ~(clr_status & WriteData[ST_OVERFLOW]));
    end
  end

endmodule
